instruction_memory: RTL and testbench

//   Program store for the matrix CPU. Sits on the shared 262-bit tri-state system bus.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/instruction_memory_ptr_ctrl.sv | 47 ++++
 rtl/instruction_memory.sv | 56 +++++
 tb/tb_instruction_memory.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared matrix-CPU definitions: system bus width, default program-store depth
// and the instruction word type carried on the bus.
package cpu_pkg;

    localparam int BUS_WIDTH  = 262;
    localparam int IMEM_DEPTH = 16;

    typedef logic [BUS_WIDTH-1:0] instr_word_t;

    // Bus direction requested by the block-select/load/fetch inputs.
    typedef enum logic [1:0] {
        BUS_IDLE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_FETCH = 2'd2
    } bus_op_e;

    // Load has priority over fetch so the block never fights the writer.
    function automatic bus_op_e decode_op(input logic enable, input logic in, input logic out);
        bus_op_e op;
        op = BUS_IDLE;
        if (enable && in) begin
            op = BUS_LOAD;
        end else if (enable && out) begin
            op = BUS_FETCH;
        end
        return op;
    endfunction

endpackage

// File: rtl/instruction_memory_ptr_ctrl.sv
// Write/read pointer and fill-count bookkeeping for the instruction store.
// Pointers saturate: writes stop at DEPTH, reads stop at the fill count.
module imem_ptr_ctrl
    import cpu_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  bus_op_e       op,
    output logic [AW-1:0] waddr,
    output logic [AW-1:0] raddr,
    output logic          write_en,
    output logic          full,
    output logic          avail
);

    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [AW:0] count;

    assign full     = (count == FULL_COUNT);
    assign avail    = (rptr < count);
    assign write_en = (op == BUS_LOAD) && !full;
    assign waddr    = wptr[AW-1:0];
    assign raddr    = rptr[AW-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (write_en) begin
                wptr  <= wptr + 1'b1;
                count <= count + 1'b1;
            end
            if ((op == BUS_FETCH) && avail) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instruction_memory.sv
// Program store on the shared tri-state system bus: sequential load from the
// bus, in-order fetch back onto it, all-zero NOP once the program is exhausted.
module instruction_memory
    import cpu_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int DEPTH = IMEM_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    inout  wire [WIDTH-1:0]  bus,
    input  logic             in,
    input  logic             out,
    input  logic             enable
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic             write_en;
    logic             full;
    logic             avail;
    logic             drive_en;
    logic [WIDTH-1:0] drive_word;
    bus_op_e          op;

    assign op = decode_op(enable, in, out);

    imem_ptr_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ptr_ctrl (
        .clock    (clock),
        .reset    (reset),
        .op       (op),
        .waddr    (waddr),
        .raddr    (raddr),
        .write_en (write_en),
        .full     (full),
        .avail    (avail)
    );

    // Storage is deliberately not reset; the avail gate keeps stale words off the bus.
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[waddr] <= bus;
        end
    end

    assign drive_en   = reset && (op == BUS_FETCH);
    assign drive_word = avail ? mem[raddr] : '0;
    assign bus        = drive_en ? drive_word : 'z;

endmodule

// File: tb/tb_instruction_memory.sv
// Directed plus randomized checks of the instruction store against a queue model
// of the load order and a fetch index.
module tb_instruction_memory;

    localparam int W     = 262;
    localparam int DEPTH = 16;
    localparam logic [W-1:0] RELEASED = '1;

    logic clock = 1'b0;
    logic reset;
    logic in;
    logic out;
    logic enable;
    logic tb_oe;
    logic [W-1:0] tb_drv;
    tri1 [W-1:0] bus;

    int n_checks = 0;
    int n_pass = 0;

    logic [W-1:0] exp_q[$];
    int rd_idx = 0;

    assign bus = tb_oe ? tb_drv : 'z;

    always #5 clock = ~clock;

    instruction_memory #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .in     (in),
        .out    (out),
        .enable (enable)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_fetch();
        return (rd_idx < exp_q.size()) ? exp_q[rd_idx] : '0;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) begin
            r = {r[W-33:0], 32'($urandom)};
        end
        r[7] = 1'b0;
        return r;
    endfunction

    // One clock cycle with the given controls; the bench drives the bus whenever in=1.
    task automatic op(input string tag, input logic en, input logic ld, input logic ft,
                      input logic [W-1:0] word);
        enable = en;
        in     = ld;
        out    = ft;
        tb_drv = word;
        tb_oe  = ld;
        #1;
        if (ld) begin
            check({tag, "/wrbus"}, bus, word);
        end else if (en && ft) begin
            check(tag, bus, model_fetch());
        end else begin
            check({tag, "/z"}, bus, RELEASED);
        end
        @(posedge clock);
        #1;
        if (en && ld) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(word);
        end else if (en && ft) begin
            if (rd_idx < exp_q.size()) rd_idx++;
        end
        enable = 1'b0;
        in     = 1'b0;
        out    = 1'b0;
        tb_oe  = 1'b0;
    endtask

    // Assert reset asynchronously while a fetch is in progress.
    task automatic do_reset();
        enable = 1'b1;
        out    = 1'b1;
        in     = 1'b0;
        tb_oe  = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_z", bus, RELEASED);
        @(posedge clock);
        #1;
        check("rst_hold_z", bus, RELEASED);
        reset  = 1'b1;
        enable = 1'b0;
        out    = 1'b0;
        exp_q.delete();
        rd_idx = 0;
    endtask

    initial begin
        logic [W-1:0] w;
        reset  = 1'b0;
        in     = 1'b0;
        out    = 1'b1;
        enable = 1'b1;
        tb_oe  = 1'b0;
        tb_drv = '0;
        #1;
        check("por_z", bus, RELEASED);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        out   = 1'b0;

        // Reset in the middle of a loaded program, then fetch sees an empty store.
        op("t1_ld0", 1, 1, 0, rand_word());
        op("t1_ld1", 1, 1, 0, rand_word());
        op("t1_ft0", 1, 0, 1, '0);
        do_reset();
        op("t1_empty", 1, 0, 1, '0);

        // Single zero word, then saturation on NOP.
        op("t2_ld", 1, 1, 0, '0);
        for (int i = 0; i < 3; i++) op("t2_ft", 1, 0, 1, '0);

        // Three small words fetched in order, then NOP.
        do_reset();
        for (int i = 1; i <= 3; i++) op("t3_ld", 1, 1, 0, W'(i));
        for (int i = 0; i < 4; i++) op("t3_ft", 1, 0, 1, '0);

        // Overfill: only the first DEPTH words survive.
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            w = rand_word();
            w[6:0] = 7'(i);
            op("t4_ld", 1, 1, 0, w);
        end
        // Load+fetch at full with nobody driving: block must stay off the bus.
        enable = 1'b1;
        in     = 1'b1;
        out    = 1'b1;
        #1;
        check("t5_both_full_z", bus, RELEASED);
        @(posedge clock);
        #1;
        enable = 1'b0;
        in     = 1'b0;
        out    = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) op("t4_ft", 1, 0, 1, '0);

        // Disabled block ignores load and fetch; load+fetch together writes.
        do_reset();
        op("t5_ld", 1, 1, 0, rand_word());
        op("t5_dis_both", 0, 1, 1, rand_word());
        op("t5_dis_ft", 0, 0, 1, '0);
        op("t5_dis_ld", 0, 1, 0, rand_word());
        op("t5_both", 1, 1, 1, rand_word());
        for (int i = 0; i < 3; i++) op("t5_ft", 1, 0, 1, '0);

        // Live append behind the read pointer.
        do_reset();
        op("t6_ldA", 1, 1, 0, W'(32'hA));
        op("t6_ftA", 1, 0, 1, '0);
        op("t6_ldB", 1, 1, 0, W'(32'hB));
        op("t6_ftB", 1, 0, 1, '0);
        op("t6_nop", 1, 0, 1, '0);

        // Randomized mix of every control combination.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (i % 73 == 72) do_reset();
            if (sel <= 2) op("rnd_ld", 1, 1, 0, rand_word());
            else if (sel <= 6) op("rnd_ft", 1, 0, 1, '0);
            else if (sel == 7) op("rnd_idle", 1, 0, 0, '0);
            else if (sel == 8) op("rnd_both", 1, 1, 1, rand_word());
            else op("rnd_dis", 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_word());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
